// File: rtl/iommu_ddtc_ctrl.sv
// Device-directory translation cache controller: arbitrates two lookup requesters, walks on miss, fills, and services invalidations.
// Define IOMMU_DDTC_CTRL_PERF_EN to add saturating hit/miss counters (hit_cnt_o, miss_cnt_o).
module iommu_ddtc_ctrl #(
    parameter int DEV_ID_W = 24,
    parameter int CNT_W    = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [1:0]            req_valid_i,
    output logic [1:0]            req_ready_o,
    input  logic [2*DEV_ID_W-1:0] req_device_id_i,
    output logic [1:0]            rsp_valid_o,
    input  logic [1:0]            rsp_ready_i,
    output logic                  rsp_hit_o,
    output logic                  rsp_fault_o,
    output logic                  ddtc_lookup_o,
    output logic                  ddtc_fill_o,
    output logic                  ddtc_inval_o,
    output logic [DEV_ID_W-1:0]   ddtc_device_id_o,
    input  logic                  ddtc_lkup_fill_done_i,
    input  logic                  ddtc_hit_i,
    input  logic                  ddtc_inval_done_i,
    output logic [DEV_ID_W-1:0]   ddtc_inval_did_o,
    output logic                  ddtc_inval_dv_o,
    output logic                  walk_req_o,
    output logic [DEV_ID_W-1:0]   walk_device_id_o,
    input  logic                  walk_done_i,
    input  logic                  walk_fault_i,
    input  logic                  inval_req_i,
    input  logic                  inval_dv_i,
    input  logic [DEV_ID_W-1:0]   inval_did_i,
    output logic                  inval_ack_o
`ifdef IOMMU_DDTC_CTRL_PERF_EN
    ,
    output logic [CNT_W-1:0]      hit_cnt_o,
    output logic [CNT_W-1:0]      miss_cnt_o
`endif
);

    if (DEV_ID_W < 1 || CNT_W < 1) begin : g_param_check
        $error("iommu_ddtc_ctrl: DEV_ID_W and CNT_W must be positive");
    end

    typedef enum logic [2:0] {IDLE, LOOKUP, WALK, FILL, RESP, INVAL} state_t;

    state_t                state_q, state_d;
    logic                  grant_q, grant_d;
    logic                  rr_q, rr_d;
    logic                  stale_q, stale_d;
    logic [DEV_ID_W-1:0]   dev_id_q, dev_id_d;
    logic                  lookup_q, lookup_d;
    logic                  fill_q, fill_d;
    logic                  inval_q, inval_d;
    logic                  walk_q, walk_d;
    logic [1:0]            rsp_valid_q, rsp_valid_d;
    logic                  hit_q, hit_d;
    logic                  fault_q, fault_d;
    logic                  ack_q, ack_d;
    logic                  inval_dv_q, inval_dv_d;
    logic [DEV_ID_W-1:0]   inval_did_q, inval_did_d;
    logic [DEV_ID_W-1:0]   ddtc_id_q, ddtc_id_d;
    logic [DEV_ID_W-1:0]   walk_id_q, walk_id_d;

    logic                  gnt;
    logic [DEV_ID_W-1:0]   gnt_id;
    logic                  stale_hit;

`ifdef IOMMU_DDTC_CTRL_PERF_EN
    logic [CNT_W-1:0]      hit_cnt_q, hit_cnt_d;
    logic [CNT_W-1:0]      miss_cnt_q, miss_cnt_d;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction
`endif

    // With both requesters valid the pointer decides; otherwise the lone requester wins.
    assign gnt       = (req_valid_i == 2'b11) ? rr_q : req_valid_i[1];
    assign gnt_id    = gnt ? req_device_id_i[DEV_ID_W +: DEV_ID_W] : req_device_id_i[0 +: DEV_ID_W];
    assign stale_hit = inval_req_i && (!inval_dv_i || (inval_did_i == dev_id_q));

    always_comb begin
        state_d     = state_q;
        grant_d     = grant_q;
        rr_d        = rr_q;
        stale_d     = stale_q;
        dev_id_d    = dev_id_q;
        lookup_d    = 1'b0;
        fill_d      = 1'b0;
        inval_d     = 1'b0;
        walk_d      = 1'b0;
        rsp_valid_d = 2'b00;
        hit_d       = hit_q;
        fault_d     = fault_q;
        ack_d       = 1'b0;
        inval_dv_d  = 1'b0;
        inval_did_d = '0;
        ddtc_id_d   = '0;
        walk_id_d   = '0;
        req_ready_o = 2'b00;
`ifdef IOMMU_DDTC_CTRL_PERF_EN
        hit_cnt_d   = hit_cnt_q;
        miss_cnt_d  = miss_cnt_q;
`endif
        case (state_q)
            IDLE: begin
                // The invalidation requester drops its request only after seeing the ack, so that cycle is skipped.
                if (ack_q) begin
                    state_d = IDLE;
                end else if (inval_req_i) begin
                    state_d     = INVAL;
                    inval_d     = 1'b1;
                    inval_dv_d  = inval_dv_i;
                    inval_did_d = inval_did_i;
                end else if (|req_valid_i) begin
                    req_ready_o[gnt] = 1'b1;
                    grant_d   = gnt;
                    rr_d      = ~gnt;
                    dev_id_d  = gnt_id;
                    stale_d   = 1'b0;
                    state_d   = LOOKUP;
                    lookup_d  = 1'b1;
                    ddtc_id_d = gnt_id;
                end
            end
            LOOKUP: begin
                if (ddtc_lkup_fill_done_i) begin
`ifdef IOMMU_DDTC_CTRL_PERF_EN
                    if (ddtc_hit_i) hit_cnt_d = sat_inc(hit_cnt_q);
                    else            miss_cnt_d = sat_inc(miss_cnt_q);
`endif
                    if (ddtc_hit_i) begin
                        state_d              = RESP;
                        rsp_valid_d[grant_q] = 1'b1;
                        hit_d                = 1'b1;
                        fault_d              = 1'b0;
                    end else begin
                        state_d   = WALK;
                        walk_d    = 1'b1;
                        walk_id_d = dev_id_q;
                    end
                end else begin
                    lookup_d  = 1'b1;
                    ddtc_id_d = dev_id_q;
                end
            end
            WALK: begin
                if (stale_hit) stale_d = 1'b1;
                if (walk_done_i) begin
                    if (walk_fault_i || stale_q || stale_hit) begin
                        state_d              = RESP;
                        rsp_valid_d[grant_q] = 1'b1;
                        hit_d                = 1'b0;
                        fault_d              = walk_fault_i;
                    end else begin
                        state_d   = FILL;
                        fill_d    = 1'b1;
                        ddtc_id_d = dev_id_q;
                    end
                end else begin
                    walk_d    = 1'b1;
                    walk_id_d = dev_id_q;
                end
            end
            FILL: begin
                if (ddtc_lkup_fill_done_i) begin
                    state_d              = RESP;
                    rsp_valid_d[grant_q] = 1'b1;
                    hit_d                = 1'b0;
                    fault_d              = 1'b0;
                end else begin
                    fill_d    = 1'b1;
                    ddtc_id_d = dev_id_q;
                end
            end
            RESP: begin
                if (rsp_ready_i[grant_q]) begin
                    state_d = IDLE;
                    hit_d   = 1'b0;
                    fault_d = 1'b0;
                end else begin
                    rsp_valid_d[grant_q] = 1'b1;
                end
            end
            INVAL: begin
                if (ddtc_inval_done_i) begin
                    state_d = IDLE;
                    ack_d   = 1'b1;
                end else begin
                    inval_d     = 1'b1;
                    inval_dv_d  = inval_dv_i;
                    inval_did_d = inval_did_i;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            grant_q     <= 1'b0;
            rr_q        <= 1'b0;
            stale_q     <= 1'b0;
            dev_id_q    <= '0;
            lookup_q    <= 1'b0;
            fill_q      <= 1'b0;
            inval_q     <= 1'b0;
            walk_q      <= 1'b0;
            rsp_valid_q <= 2'b00;
            hit_q       <= 1'b0;
            fault_q     <= 1'b0;
            ack_q       <= 1'b0;
            inval_dv_q  <= 1'b0;
            inval_did_q <= '0;
            ddtc_id_q   <= '0;
            walk_id_q   <= '0;
`ifdef IOMMU_DDTC_CTRL_PERF_EN
            hit_cnt_q   <= '0;
            miss_cnt_q  <= '0;
`endif
        end else begin
            state_q     <= state_d;
            grant_q     <= grant_d;
            rr_q        <= rr_d;
            stale_q     <= stale_d;
            dev_id_q    <= dev_id_d;
            lookup_q    <= lookup_d;
            fill_q      <= fill_d;
            inval_q     <= inval_d;
            walk_q      <= walk_d;
            rsp_valid_q <= rsp_valid_d;
            hit_q       <= hit_d;
            fault_q     <= fault_d;
            ack_q       <= ack_d;
            inval_dv_q  <= inval_dv_d;
            inval_did_q <= inval_did_d;
            ddtc_id_q   <= ddtc_id_d;
            walk_id_q   <= walk_id_d;
`ifdef IOMMU_DDTC_CTRL_PERF_EN
            hit_cnt_q   <= hit_cnt_d;
            miss_cnt_q  <= miss_cnt_d;
`endif
        end
    end

    assign rsp_valid_o      = rsp_valid_q;
    assign rsp_hit_o        = hit_q;
    assign rsp_fault_o      = fault_q;
    assign ddtc_lookup_o    = lookup_q;
    assign ddtc_fill_o      = fill_q;
    assign ddtc_inval_o     = inval_q;
    assign ddtc_device_id_o = ddtc_id_q;
    assign ddtc_inval_dv_o  = inval_dv_q;
    assign ddtc_inval_did_o = inval_did_q;
    assign walk_req_o       = walk_q;
    assign walk_device_id_o = walk_id_q;
    assign inval_ack_o      = ack_q;
`ifdef IOMMU_DDTC_CTRL_PERF_EN
    assign hit_cnt_o        = hit_cnt_q;
    assign miss_cnt_o       = miss_cnt_q;
`endif

endmodule

// File: tb/tb_iommu_ddtc_ctrl.sv
// Directed-vector bench for iommu_ddtc_ctrl: hit/miss/fault paths, round-robin, stale walks, invalidation and reset.
module tb_iommu_ddtc_ctrl;
    localparam int DEV_ID_W = 24;
    localparam int CNT_W    = 32;

    logic                  clk = 1'b0;
    logic                  rst_n = 1'b0;
    logic [1:0]            req_valid_i = '0;
    logic [1:0]            req_ready_o;
    logic [2*DEV_ID_W-1:0] req_device_id_i = '0;
    logic [1:0]            rsp_valid_o;
    logic [1:0]            rsp_ready_i = '0;
    logic                  rsp_hit_o, rsp_fault_o;
    logic                  ddtc_lookup_o, ddtc_fill_o, ddtc_inval_o;
    logic [DEV_ID_W-1:0]   ddtc_device_id_o;
    logic                  ddtc_lkup_fill_done_i = 1'b0;
    logic                  ddtc_hit_i = 1'b0;
    logic                  ddtc_inval_done_i = 1'b0;
    logic [DEV_ID_W-1:0]   ddtc_inval_did_o;
    logic                  ddtc_inval_dv_o;
    logic                  walk_req_o;
    logic [DEV_ID_W-1:0]   walk_device_id_o;
    logic                  walk_done_i = 1'b0;
    logic                  walk_fault_i = 1'b0;
    logic                  inval_req_i = 1'b0;
    logic                  inval_dv_i = 1'b0;
    logic [DEV_ID_W-1:0]   inval_did_i = '0;
    logic                  inval_ack_o;
`ifdef IOMMU_DDTC_CTRL_PERF_EN
    logic [CNT_W-1:0]      hit_cnt_o, miss_cnt_o;
`endif

    always #5 clk = ~clk;

    iommu_ddtc_ctrl #(.DEV_ID_W(DEV_ID_W), .CNT_W(CNT_W)) dut (
        .clk                   (clk),
        .rst_n                 (rst_n),
        .req_valid_i           (req_valid_i),
        .req_ready_o           (req_ready_o),
        .req_device_id_i       (req_device_id_i),
        .rsp_valid_o           (rsp_valid_o),
        .rsp_ready_i           (rsp_ready_i),
        .rsp_hit_o             (rsp_hit_o),
        .rsp_fault_o           (rsp_fault_o),
        .ddtc_lookup_o         (ddtc_lookup_o),
        .ddtc_fill_o           (ddtc_fill_o),
        .ddtc_inval_o          (ddtc_inval_o),
        .ddtc_device_id_o      (ddtc_device_id_o),
        .ddtc_lkup_fill_done_i (ddtc_lkup_fill_done_i),
        .ddtc_hit_i            (ddtc_hit_i),
        .ddtc_inval_done_i     (ddtc_inval_done_i),
        .ddtc_inval_did_o      (ddtc_inval_did_o),
        .ddtc_inval_dv_o       (ddtc_inval_dv_o),
        .walk_req_o            (walk_req_o),
        .walk_device_id_o      (walk_device_id_o),
        .walk_done_i           (walk_done_i),
        .walk_fault_i          (walk_fault_i),
        .inval_req_i           (inval_req_i),
        .inval_dv_i            (inval_dv_i),
        .inval_did_i           (inval_did_i),
        .inval_ack_o           (inval_ack_o)
`ifdef IOMMU_DDTC_CTRL_PERF_EN
        ,
        .hit_cnt_o             (hit_cnt_o),
        .miss_cnt_o            (miss_cnt_o)
`endif
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [95:0] got, input logic [95:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    function automatic logic [95:0] all_outs();
        return {12'h000, req_ready_o, rsp_valid_o, rsp_hit_o, rsp_fault_o,
                ddtc_lookup_o, ddtc_fill_o, ddtc_inval_o, ddtc_inval_dv_o,
                walk_req_o, inval_ack_o, ddtc_device_id_o, ddtc_inval_did_o, walk_device_id_o};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Cache commands must never overlap.
    always @(negedge clk)
        check("cmd_exclusive", 96'($countones({ddtc_lookup_o, ddtc_fill_o, ddtc_inval_o}) <= 1), 96'd1);

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [1:0] g;

        tick(); tick();
        check("reset_outs", all_outs(), '0);
        rst_n = 1'b1;
        tick();
        check("idle_outs", all_outs(), '0);

        // Hit: grant N, lookup N+1, response N+2.
        req_device_id_i = {24'h0000A5, 24'h000042};
        req_valid_i = 2'b01; #1;
        check("t1_grant", 96'(req_ready_o), 96'(2'b01));
        tick(); req_valid_i = '0; ddtc_lkup_fill_done_i = 1'b1; ddtc_hit_i = 1'b1;
        check("t1_lookup", 96'({ddtc_lookup_o, ddtc_device_id_o, req_ready_o}), 96'({1'b1, 24'h000042, 2'b00}));
        tick(); ddtc_lkup_fill_done_i = 1'b0; ddtc_hit_i = 1'b0;
        check("t1_rsp", 96'({rsp_valid_o, rsp_hit_o, rsp_fault_o, walk_req_o, ddtc_lookup_o}),
              96'({2'b01, 1'b1, 1'b0, 1'b0, 1'b0}));
        rsp_ready_i = 2'b01;
        tick(); rsp_ready_i = '0;
        check("t1_idle", all_outs(), '0);

        // Miss, five-cycle walk, fill, response.
        req_valid_i = 2'b10; #1;
        check("t2_grant", 96'(req_ready_o), 96'(2'b10));
        tick(); req_valid_i = '0; ddtc_lkup_fill_done_i = 1'b1;
        tick(); ddtc_lkup_fill_done_i = 1'b0;
        check("t2_walk", 96'({walk_req_o, walk_device_id_o, ddtc_lookup_o}), 96'({1'b1, 24'h0000A5, 1'b0}));
        repeat (4) tick();
        check("t2_walk_held", 96'(walk_req_o), 96'd1);
        walk_done_i = 1'b1;
        tick(); walk_done_i = 1'b0;
        check("t2_fill", 96'({ddtc_fill_o, ddtc_device_id_o, walk_req_o}), 96'({1'b1, 24'h0000A5, 1'b0}));
        ddtc_lkup_fill_done_i = 1'b1;
        tick(); ddtc_lkup_fill_done_i = 1'b0;
        check("t2_rsp", 96'({rsp_valid_o, rsp_hit_o, rsp_fault_o, ddtc_fill_o}), 96'({2'b10, 1'b0, 1'b0, 1'b0}));
        rsp_ready_i = 2'b10;
        tick(); rsp_ready_i = '0;
        check("t2_idle", all_outs(), '0);

        // Walk fault: response with fault, no fill.
        req_valid_i = 2'b10;
        tick(); req_valid_i = '0; ddtc_lkup_fill_done_i = 1'b1;
        tick(); ddtc_lkup_fill_done_i = 1'b0; walk_done_i = 1'b1; walk_fault_i = 1'b1;
        tick(); walk_done_i = 1'b0; walk_fault_i = 1'b0;
        check("t2f_rsp", 96'({rsp_valid_o, rsp_hit_o, rsp_fault_o, ddtc_fill_o}), 96'({2'b10, 1'b0, 1'b1, 1'b0}));
        rsp_ready_i = 2'b10;
        tick(); rsp_ready_i = '0;

        // Both requesters valid: grants alternate 0,1,0,1.
        req_valid_i = 2'b11;
        for (int i = 0; i < 4; i++) begin
            #1; g = req_ready_o;
            check($sformatf("t3_grant%0d", i), 96'(g), (i % 2 == 0) ? 96'(2'b01) : 96'(2'b10));
            tick(); ddtc_lkup_fill_done_i = 1'b1; ddtc_hit_i = 1'b1;
            tick(); ddtc_lkup_fill_done_i = 1'b0; ddtc_hit_i = 1'b0;
            check($sformatf("t3_rsp%0d", i), 96'(rsp_valid_o), (i % 2 == 0) ? 96'(2'b01) : 96'(2'b10));
            rsp_ready_i = rsp_valid_o;
            tick(); rsp_ready_i = '0;
        end
        req_valid_i = '0;

        // Matching invalidation during walk: no fill, then invalidation serviced.
        req_valid_i = 2'b10;
        tick(); req_valid_i = '0; ddtc_lkup_fill_done_i = 1'b1;
        tick(); ddtc_lkup_fill_done_i = 1'b0;
        inval_req_i = 1'b1; inval_dv_i = 1'b1; inval_did_i = 24'h0000A5;
        tick(); walk_done_i = 1'b1;
        tick(); walk_done_i = 1'b0;
        check("t4_nofill", 96'({ddtc_fill_o, ddtc_inval_o, rsp_valid_o, rsp_hit_o, rsp_fault_o}),
              96'({1'b0, 1'b0, 2'b10, 1'b0, 1'b0}));
        rsp_ready_i = 2'b10;
        tick(); rsp_ready_i = '0;
        check("t4_idle", 96'({rsp_valid_o, ddtc_inval_o, inval_ack_o}), 96'd0);
        tick(); ddtc_inval_done_i = 1'b1;
        check("t4_inval", 96'({ddtc_inval_o, ddtc_inval_dv_o, ddtc_inval_did_o}), 96'({1'b1, 1'b1, 24'h0000A5}));
        tick(); ddtc_inval_done_i = 1'b0;
        check("t4_ack", 96'({inval_ack_o, ddtc_inval_o}), 96'(2'b10));
        inval_req_i = 1'b0;
        tick();
        check("t4_ack_pulse", all_outs(), '0);

        // Non-matching invalidation during walk: fill proceeds, invalidation waits.
        req_valid_i = 2'b01;
        tick(); req_valid_i = '0; ddtc_lkup_fill_done_i = 1'b1;
        tick(); ddtc_lkup_fill_done_i = 1'b0;
        inval_req_i = 1'b1; inval_dv_i = 1'b1; inval_did_i = 24'h000077; walk_done_i = 1'b1;
        tick(); walk_done_i = 1'b0;
        check("t5_fill", 96'({ddtc_fill_o, ddtc_inval_o, ddtc_device_id_o}), 96'({1'b1, 1'b0, 24'h000042}));
        ddtc_lkup_fill_done_i = 1'b1;
        tick(); ddtc_lkup_fill_done_i = 1'b0;
        check("t5_rsp_wait", 96'({rsp_valid_o, ddtc_inval_o}), 96'({2'b01, 1'b0}));
        rsp_ready_i = 2'b01;
        tick(); rsp_ready_i = '0;
        tick(); ddtc_inval_done_i = 1'b1;
        check("t5_inval", 96'({ddtc_inval_o, ddtc_inval_did_o}), 96'({1'b1, 24'h000077}));
        tick(); ddtc_inval_done_i = 1'b0; inval_req_i = 1'b0;
        tick();

        // Invalidation and both requests together: invalidation first, grant after ack.
        inval_req_i = 1'b1; inval_dv_i = 1'b0; inval_did_i = '0; req_valid_i = 2'b11; #1;
        check("t6_no_grant", 96'(req_ready_o), 96'd0);
        tick(); ddtc_inval_done_i = 1'b1;
        check("t6_inval", 96'({ddtc_inval_o, ddtc_inval_dv_o, req_ready_o}), 96'({1'b1, 1'b0, 2'b00}));
        tick(); ddtc_inval_done_i = 1'b0;
        check("t6_ack", 96'({inval_ack_o, req_ready_o}), 96'({1'b1, 2'b00}));
        inval_req_i = 1'b0;
        tick();
        check("t6_grant", 96'(req_ready_o), 96'(2'b10));

        // Reset during walk; a late walk_done is ignored.
        tick(); req_valid_i = '0; ddtc_lkup_fill_done_i = 1'b1;
        tick(); ddtc_lkup_fill_done_i = 1'b0;
        check("t7_walk", 96'({walk_req_o, walk_device_id_o}), 96'({1'b1, 24'h0000A5}));
`ifdef IOMMU_DDTC_CTRL_PERF_EN
        check("perf_hits", 96'(hit_cnt_o), 96'd5);
        check("perf_misses", 96'(miss_cnt_o), 96'd5);
`endif
        rst_n = 1'b0; #1;
        check("t7_rst_outs", all_outs(), '0);
        tick(); rst_n = 1'b1; walk_done_i = 1'b1;
        tick(); walk_done_i = 1'b0;
        check("t7_ignore_done", all_outs(), '0);
        tick();
        check("t7_still_idle", all_outs(), '0);
`ifdef IOMMU_DDTC_CTRL_PERF_EN
        check("perf_rst", 96'({hit_cnt_o, miss_cnt_o}), 96'd0);
`endif
        req_valid_i = 2'b11; #1;
        check("t7_rr_reset", 96'(req_ready_o), 96'(2'b01));
        tick(); req_valid_i = '0;
        check("t7_lookup", 96'({ddtc_lookup_o, ddtc_device_id_o}), 96'({1'b1, 24'h000042}));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/iommu_ddtc_ctrl.md
IOMMU_DDTC_CTRL -- requirements
Module: iommu_ddtc_ctrl

Interface
REQ-001 SHALL have parameter DEV_ID_W, default 24, device_id width.
REQ-002 SHALL have parameter CNT_W, default 32, perf counter width.
REQ-003 SHALL have ports: clk  in  1  clock, rising edge; rst_n  in  1  reset, asynchronous, active-low.
REQ-004 SHALL have ports: req_valid_i  in  2  per-requester lookup request; req_ready_o  out  2  one-cycle grant pulse; req_device_id_i  in  2*DEV_ID_W  requester n at bits [n*DEV_ID_W +: DEV_ID_W].
REQ-005 SHALL have ports: rsp_valid_o  out  2  response to granted requester; rsp_ready_i  in  2  response accept; rsp_hit_o  out  1  DDTC hit; rsp_fault_o  out  1  walk fault.
REQ-006 SHALL have ports: ddtc_lookup_o, ddtc_fill_o, ddtc_inval_o  out  1 each  cache commands; ddtc_device_id_o  out  DEV_ID_W; ddtc_lkup_fill_done_i, ddtc_hit_i, ddtc_inval_done_i  in  1 each.
REQ-007 SHALL have ports: ddtc_inval_did_o  out  DEV_ID_W; ddtc_inval_dv_o  out  1  device-specific invalidation.
REQ-008 SHALL have ports: walk_req_o  out  1; walk_device_id_o  out  DEV_ID_W; walk_done_i  in  1  one-cycle pulse; walk_fault_i  in  1  qualified by walk_done_i.
REQ-009 SHALL have ports: inval_req_i  in  1  held until acked; inval_dv_i  in  1; inval_did_i  in  DEV_ID_W; inval_ack_o  out  1  one-cycle pulse.
REQ-010 SHALL have ports (IOMMU_DDTC_CTRL_PERF_EN only): hit_cnt_o, miss_cnt_o  out  CNT_W.

Function
REQ-011 SHALL implement FSM states IDLE, LOOKUP, WALK, FILL, RESP, INVAL.
REQ-012 IDLE: inval_req_i high SHALL go to INVAL, taking priority over pending requests.
REQ-013 IDLE, no inval: any req_valid_i SHALL be granted round-robin, pulsing req_ready_o[g] and latching g and its device_id, then go to LOOKUP.
REQ-014 Round-robin pointer SHALL favour the non-granted requester after every grant; with a single requester valid, that requester SHALL always win.
REQ-015 LOOKUP: ddtc_lookup_o=1 with latched id until ddtc_lkup_fill_done_i; ddtc_hit_i=1 SHALL go to RESP with hit=1, else WALK.
REQ-016 WALK: walk_req_o=1 held until walk_done_i; walk_fault_i=1 SHALL go to RESP with fault=1 and no fill.
REQ-017 WALK, no fault: SHALL go to FILL unless stale flag is set, then RESP with hit=0, fault=0 and no fill.
REQ-018 Stale flag SHALL be set when inval_req_i is seen in WALK with inval_dv_i=0 or inval_did_i equal to latched id; it SHALL clear on entry to LOOKUP.
REQ-019 FILL: ddtc_fill_o=1 until ddtc_lkup_fill_done_i SHALL go to RESP with hit=0, fault=0.
REQ-020 RESP: rsp_valid_o[g]=1 with stable hit/fault until rsp_ready_i[g]; then go to IDLE.
REQ-021 INVAL: ddtc_inval_o=1 with ddtc_inval_dv_o/ddtc_inval_did_o driven from inputs until ddtc_inval_done_i; then pulse inval_ack_o and go to IDLE.
REQ-022 At most one of ddtc_lookup_o, ddtc_fill_o, ddtc_inval_o SHALL be high in any cycle.
REQ-023 Hit latency SHALL be: grant cycle N, LOOKUP N+1 with same-cycle done, rsp_valid_o at N+2.
REQ-024 inval_req_i arriving in LOOKUP/WALK/FILL/RESP SHALL wait and be serviced at the next IDLE, before any new grant.

Reset
REQ-025 Reset SHALL force IDLE; all outputs 0; RR pointer favours requester 0; stale flag, latched id and counters 0.
REQ-026 Reset mid-operation SHALL abandon it with no response or ack; a late walk_done_i in IDLE SHALL be ignored.

Configuration
REQ-027 With IOMMU_DDTC_CTRL_PERF_EN defined, hit_cnt_o SHALL increment on each LOOKUP hit and miss_cnt_o on each LOOKUP miss, saturating at all-ones.
REQ-028 Without IOMMU_DDTC_CTRL_PERF_EN, the counters and their ports SHALL be absent; behaviour is otherwise identical.

Verification
REQ-029 Req0 id 0x000042 and cache hit in same cycle -> ddtc_lookup_o at N+1, rsp_valid_o=01 with hit=1 at N+2, no walk_req_o.
REQ-030 Req1 id 0x0000A5 misses, walk_done_i after 5 cycles, fault=0 -> ddtc_fill_o one cycle with id 0x0000A5, then RESP hit=0, fault=0.
REQ-031 Both requesters valid for 4 transactions -> grants 0,1,0,1.
REQ-032 inval_req_i dv=1 id 0x0000A5 during WALK for 0x0000A5 -> no ddtc_fill_o, RESP hit=0, then INVAL, inval_ack_o pulse.
REQ-033 inval_req_i and req_valid_i=11 both in IDLE -> INVAL first; grant only after inval_ack_o.
REQ-034 rst_n low during WALK, walk_done_i pulses after release -> FSM stays IDLE, all outputs 0.
